// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: decoder FSM encoding, pixel width and the
// clock-count derivation used by both the transmitter and the receiver.
package ws2812_pkg;

    localparam int WS2812_WIDTH    = 24;
    localparam int CLK_FRE_DEFAULT = 27_000_000;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } ws2812_state_t;

    // Whole MHz first, then scale: keeps every threshold a plain integer.
    function automatic int ws2812_clks(input int clk_fre, input int ns);
        return clk_fre / 1_000_000 * ns / 1000;
    endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Receiver output bundle. Strobe-only, no backpressure: pix_valid, frame_end
// and err are single-cycle pulses with no ready; pix_data/pix_idx are valid while pix_valid is high.
interface ws2812_rx_if;
    import ws2812_pkg::*;

    logic [WS2812_WIDTH-1:0] pix_data;
    logic                    pix_valid;
    logic [7:0]              pix_idx;
    logic                    frame_end;
    logic                    err;
    ws2812_state_t           dbg_state;

    modport master (
        output pix_data, pix_valid, pix_idx, frame_end, err, dbg_state
    );

    modport slave (
        input pix_data, pix_valid, pix_idx, frame_end, err, dbg_state
    );

endinterface

// File: rtl/ws2812_pulse_meas.sv
// Synchronizes din, detects edges and measures the run length of the
// current line level with a 16-bit saturating counter.
module ws2812_pulse_meas (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic        lvl,
    output logic        rise,
    output logic        fall,
    output logic [15:0] cnt
);

    logic sync_0;
    logic ds;

    // cnt is the run length of lvl including this cycle; rise/fall look one
    // sample ahead on ds, so on fall cnt already holds the full high time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0 <= 1'b0;
            ds     <= 1'b0;
            lvl    <= 1'b0;
            cnt    <= 16'd0;
        end else begin
            sync_0 <= din;
            ds     <= sync_0;
            lvl    <= ds;
            if (ds != lvl) begin
                cnt <= 16'd1;
            end else if (cnt != 16'hffff) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign rise = ds & ~lvl;
    assign fall = ~ds & lvl;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial decoder: classifies high pulses into bits, assembles 24-bit
// pixels LSB first, and reports frame gaps and timing violations.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FRE      = CLK_FRE_DEFAULT,
    parameter int T_MIN_HIGH   = ws2812_clks(CLK_FRE, 150),
    parameter int T_BIT_THRESH = ws2812_clks(CLK_FRE, 625),
    parameter int T_MAX_HIGH   = ws2812_clks(CLK_FRE, 1200),
    parameter int T_RESET      = ws2812_clks(CLK_FRE, 50_000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    ws2812_rx_if.master rx
);

    localparam logic [15:0] MIN_C   = 16'(T_MIN_HIGH);
    localparam logic [15:0] BIT_C   = 16'(T_BIT_THRESH);
    localparam logic [15:0] MAX_C   = 16'(T_MAX_HIGH);
    localparam logic [15:0] RESET_C = 16'(T_RESET);
    localparam logic [4:0]  LAST_BIT = 5'(WS2812_WIDTH - 1);

    logic        lvl;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;

    ws2812_state_t           state;
    logic [4:0]              bit_cnt;
    logic [7:0]              pix_cnt;
    logic [WS2812_WIDTH-2:0] sr;
    logic                    bit_val;

    ws2812_pulse_meas u_meas (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .lvl   (lvl),
        .rise  (rise),
        .fall  (fall),
        .cnt   (cnt)
    );

    assign bit_val      = (cnt >= BIT_C);
    assign rx.dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_GAP;
            bit_cnt      <= 5'd0;
            pix_cnt      <= 8'd0;
            sr           <= '0;
            rx.pix_data  <= '0;
            rx.pix_idx   <= 8'd0;
            rx.pix_valid <= 1'b0;
            rx.frame_end <= 1'b0;
            rx.err       <= 1'b0;
        end else begin
            rx.pix_valid <= 1'b0;
            rx.frame_end <= 1'b0;
            rx.err       <= 1'b0;
            unique case (state)
                // A gap ending on the very cycle the line rises goes straight to HIGH.
                WAIT_GAP: begin
                    if (!lvl && cnt >= RESET_C) begin
                        state <= rise ? HIGH : IDLE;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt >= MAX_C || (fall && cnt < MIN_C)) begin
                        rx.err  <= 1'b1;
                        bit_cnt <= 5'd0;
                        pix_cnt <= 8'd0;
                        state   <= WAIT_GAP;
                    end else if (fall) begin
                        state <= LOW;
                        if (bit_cnt == LAST_BIT) begin
                            rx.pix_data  <= {bit_val, sr};
                            rx.pix_valid <= 1'b1;
                            rx.pix_idx   <= pix_cnt;
                            bit_cnt      <= 5'd0;
                            if (pix_cnt != 8'hff) begin
                                pix_cnt <= pix_cnt + 8'd1;
                            end
                        end else begin
                            sr[bit_cnt] <= bit_val;
                            bit_cnt     <= bit_cnt + 5'd1;
                        end
                    end
                end
                // The gap itself satisfies the resync wait, so even a partial-pixel error resumes in IDLE.
                LOW: begin
                    if (cnt >= RESET_C) begin
                        rx.frame_end <= 1'b1;
                        rx.err       <= (bit_cnt != 5'd0);
                        bit_cnt      <= 5'd0;
                        pix_cnt      <= 8'd0;
                        state        <= rise ? HIGH : IDLE;
                    end else if (rise) begin
                        state <= HIGH;
                    end
                end
                default: state <= WAIT_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: pixel decode, back-to-back pixels, timing
// boundaries, short/long pulse errors, partial-frame gaps and mid-pixel reset.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic clk;
  logic rst_n;
  logic din;

  ws2812_rx_if bus ();

  ws2812_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .rx    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_fe    = 0;
  int n_err   = 0;
  int n_same  = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  exp_idx_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  // scoreboard: every pixel strobe is checked against the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pix_valid) begin
        n_valid++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pix: got data %h idx %0d, required no pix_valid", bus.pix_data, bus.pix_idx);
        end else begin
          logic [23:0] ed;
          logic [7:0]  ei;
          ed = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          if (bus.pix_data !== ed || bus.pix_idx !== ei) begin
            n_fail++;
            $display("FAIL pix: got data %h idx %0d, required data %h idx %0d", bus.pix_data, bus.pix_idx, ed, ei);
          end
        end
      end
      if (bus.frame_end) n_fe++;
      if (bus.err) n_err++;
      if (bus.frame_end && bus.err) n_same++;
    end
  end

  // driver tasks
  task automatic clear_mon();
    @(posedge clk);
    n_valid = 0;
    n_fe    = 0;
    n_err   = 0;
    n_same  = 0;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    @(posedge clk);
  endtask

  task automatic push_exp(input logic [23:0] d, input logic [7:0] idx);
    exp_q.push_back(d);
    exp_idx_q.push_back(idx);
  endtask

  task automatic send_bit_hl(input int h, input int l);
    @(negedge clk);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_bit_hl(23, 11);
    else   send_bit_hl(11, 23);
  endtask

  task automatic send_bits(input logic [23:0] d, input int n);
    for (int k = 0; k < n; k++) send_bit(d[k]);
  endtask

  task automatic send_gap(input int n);
    @(negedge clk);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (bus.pix_data !== 24'h0) begin n_fail++; $display("FAIL reset_pix_data: got %h required 0", bus.pix_data); end
    n_tests++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b required 0", bus.pix_valid); end
    n_tests++; if (bus.pix_idx !== 8'h0) begin n_fail++; $display("FAIL reset_pix_idx: got %h required 0", bus.pix_idx); end
    n_tests++; if (bus.frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %b required 0", bus.frame_end); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", bus.err); end
    n_tests++; if (bus.dbg_state !== WAIT_GAP) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, WAIT_GAP); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_mon();
    push_exp(24'h000f00, 8'd0);
    send_gap(1350);
    send_bits(24'h000f00, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d required 1", n_valid); end
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL single_frame_end: got %0d required 1", n_fe); end
    n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL single_err: got %0d required 0", n_err); end
    n_tests++; if (bus.pix_data !== 24'h000f00) begin n_fail++; $display("FAIL single_hold: got %h required 000f00", bus.pix_data); end
    n_tests++; if (bus.dbg_state !== IDLE) begin n_fail++; $display("FAIL single_state: got %0d required %0d", bus.dbg_state, IDLE); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    push_exp(24'h0f0000, 8'd0);
    push_exp(24'h000f00, 8'd1);
    push_exp(24'h00000f, 8'd2);
    send_bits(24'h0f0000, 24);
    send_bits(24'h000f00, 24);
    send_bits(24'h00000f, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d required 3", n_valid); end
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL b2b_frame_end: got %0d required 1", n_fe); end
    n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d required 0", n_err); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
  endtask

  // highs cycle 4 (0), 16 (1), 15 (0), 31 (1): odd bits set -> aaaaaa
  task automatic test_boundary();
    clear_mon();
    push_exp(24'haaaaaa, 8'd0);
    for (int k = 0; k < 24; k++) begin
      case (k % 4)
        0: send_bit_hl(4, 10);
        1: send_bit_hl(16, 10);
        2: send_bit_hl(15, 10);
        default: send_bit_hl(31, 10);
      endcase
    end
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL bound_valid_count: got %0d required 1", n_valid); end
    n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL bound_err: got %0d required 0", n_err); end
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL bound_frame_end: got %0d required 1", n_fe); end
  endtask

  task automatic test_short_pulse();
    clear_mon();
    send_bits(24'hffffff, 10);
    send_bit_hl(3, 20);
    settle();
    n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL short_err: got %0d required 1", n_err); end
    send_bits(24'h5a5a5a, 24);
    settle();
    n_tests++; if (n_valid !== 0) begin n_fail++; $display("FAIL short_no_pix: got %0d required 0", n_valid); end
    n_tests++; if (n_fe !== 0) begin n_fail++; $display("FAIL short_no_fe: got %0d required 0", n_fe); end
    push_exp(24'h123456, 8'd0);
    send_gap(1350);
    send_bits(24'h123456, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL short_resync: got %0d required 1", n_valid); end
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL short_resync_fe: got %0d required 1", n_fe); end
    n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL short_err_total: got %0d required 1", n_err); end
  endtask

  // err expected 2 sync + 1 edge + 32 count cycles after din rises
  task automatic test_long_pulse();
    int err_at;
    int err_hits;
    clear_mon();
    err_at   = -1;
    err_hits = 0;
    send_bits(24'h000015, 5);
    @(negedge clk);
    din = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.err) begin
        err_hits++;
        if (err_at < 0) err_at = i;
      end
    end
    din = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (err_at !== 35) begin n_fail++; $display("FAIL long_err_time: got %0d required 35", err_at); end
    n_tests++; if (err_hits !== 1) begin n_fail++; $display("FAIL long_err_width: got %0d required 1", err_hits); end
    send_bits(24'h777777, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 0) begin n_fail++; $display("FAIL long_no_pix: got %0d required 0", n_valid); end
    n_tests++; if (n_fe !== 0) begin n_fail++; $display("FAIL long_no_fe: got %0d required 0", n_fe); end
    push_exp(24'h0f0f0f, 8'd0);
    send_bits(24'h0f0f0f, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL long_resync: got %0d required 1", n_valid); end
    n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL long_err_total: got %0d required 1", n_err); end
  endtask

  task automatic test_gap_partial();
    clear_mon();
    send_bits(24'h0003a5, 10);
    send_gap(1350);
    settle();
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL partial_fe: got %0d required 1", n_fe); end
    n_tests++; if (n_err !== 1) begin n_fail++; $display("FAIL partial_err: got %0d required 1", n_err); end
    n_tests++; if (n_same !== 1) begin n_fail++; $display("FAIL partial_same_cycle: got %0d required 1", n_same); end
    n_tests++; if (n_valid !== 0) begin n_fail++; $display("FAIL partial_no_pix: got %0d required 0", n_valid); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_bits(24'h000abc, 12);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.pix_data !== 24'h0) begin n_fail++; $display("FAIL rmid_pix_data: got %h required 0", bus.pix_data); end
    n_tests++; if (bus.pix_valid !== 1'b0 || bus.frame_end !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_strobes: got %b%b%b required 000", bus.pix_valid, bus.frame_end, bus.err);
    end
    n_tests++; if (bus.pix_idx !== 8'h0) begin n_fail++; $display("FAIL rmid_pix_idx: got %h required 0", bus.pix_idx); end
    n_tests++; if (bus.dbg_state !== WAIT_GAP) begin n_fail++; $display("FAIL rmid_state: got %0d required %0d", bus.dbg_state, WAIT_GAP); end
    rst_n = 1'b1;
    send_bits(24'hc3c3c3, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 0) begin n_fail++; $display("FAIL rmid_no_pix: got %0d required 0", n_valid); end
    n_tests++; if (n_fe !== 0 || n_err !== 0) begin n_fail++; $display("FAIL rmid_quiet: got fe %0d err %0d required 0 0", n_fe, n_err); end
    push_exp(24'h00ff00, 8'd0);
    send_bits(24'h00ff00, 24);
    send_gap(1350);
    settle();
    n_tests++; if (n_valid !== 1) begin n_fail++; $display("FAIL rmid_resync: got %0d required 1", n_valid); end
    n_tests++; if (n_fe !== 1) begin n_fail++; $display("FAIL rmid_resync_fe: got %0d required 1", n_fe); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_short_pulse();
    test_long_pulse();
    test_gap_partial();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter CLK_FRE, default 27_000_000, clk frequency in Hz; all timing thresholds derive from it by integer arithmetic.
REQ-002 Parameter T_MIN_HIGH = CLK_FRE/1_000_000*150/1000 (4 at default): shortest legal high pulse, in clocks.
REQ-003 Parameter T_BIT_THRESH = CLK_FRE/1_000_000*625/1000 (16 at default): a high count at or above this value is a 1.
REQ-004 Parameter T_MAX_HIGH = CLK_FRE/1_000_000*1200/1000 (32 at default): a high count at or above this value is an error.
REQ-005 Parameter T_RESET = CLK_FRE/1_000_000*50 (1350 at default): low count that marks a latch/reset gap.
REQ-006 Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  1  WS2812 serial line, asynchronous to clk.
- pix_data  output  24  last complete pixel word.
- pix_valid  output  1  one-cycle strobe: pix_data and pix_idx are valid.
- pix_idx  output  8  zero-based pixel position within the current frame.
- frame_end  output  1  one-cycle strobe: reset gap detected after at least one received bit.
- err  output  1  one-cycle strobe: timing or framing violation.

Function
REQ-007 din SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized signal (ds), and all latencies are quoted from ds.
REQ-008 A single 16-bit saturating counter SHALL measure the current high or low duration of ds.
REQ-009 FSM states SHALL be WAIT_GAP, IDLE, HIGH and LOW.
REQ-010 WAIT_GAP: counts consecutive ds=0 cycles, restarts on ds=1, and moves to IDLE when the count reaches T_RESET; no outputs are produced in this state.
REQ-011 IDLE: on ds rising, clears the counter and enters HIGH.
REQ-012 HIGH: counts the high time. On ds falling:
- count < T_MIN_HIGH: err, go to WAIT_GAP.
- otherwise: the bit is (count >= T_BIT_THRESH), go to LOW.
- count reaching T_MAX_HIGH while still high: err, go to WAIT_GAP.
REQ-013 Bit order SHALL be LSB first: the k-th bit of a pixel (k = 0..23) is written to shift-register bit k.
REQ-014 On the falling edge that completes bit 23, the next cycle SHALL present pix_data, assert pix_valid for one cycle, and drive pix_idx with the current pixel count.
REQ-015 After each completed pixel, the bit counter SHALL clear and the pixel count SHALL increment, saturating at 255.
REQ-016 LOW: ds rising clears the counter and enters HIGH.
REQ-017 LOW: when the low count reaches T_RESET:
- assert frame_end for one cycle;
- clear the pixel count and bit counter;
- go to IDLE.
REQ-018 If the gap in REQ-017 arrives with the bit counter nonzero, err SHALL pulse in the same cycle as frame_end, and the partial pixel is discarded (no pix_valid).
REQ-019 Any err SHALL discard the partial pixel, clear the pixel count, and force WAIT_GAP.
REQ-020 Boundary rule: a high count exactly equal to T_BIT_THRESH decodes as 1, and exactly T_MIN_HIGH is legal.
REQ-021 pix_data SHALL hold its value between pix_valid strobes.

Reset
REQ-022 While rst_n=0, the following SHALL be forced: state=WAIT_GAP, counter=0, bit count=0, pixel count=0, pix_data=0, pix_idx=0, pix_valid=0, frame_end=0, err=0, synchronizer flops=0.
REQ-023 Reset asserted mid-pixel SHALL discard all progress; after release, the block requires a full T_RESET gap before decoding.

Structure
REQ-024 A shared package ws2812_pkg SHALL hold the FSM state encoding, WS2812_WIDTH=24 and the timing-derivation constants, shared with the existing WS2812 transmitter.
REQ-025 One sub-module, ws2812_pulse_meas (synchronizer, edge detect, saturating counter), is natural; the FSM and shift register stay in ws2812_rx.

Verification
REQ-026 After a 1350-cycle low, send 24'h000f00 with 1-bits = 23 high/11 low and 0-bits = 11 high/23 low, then a 1350-cycle low -> one pix_valid, pix_data=24'h000f00, pix_idx=0, then one frame_end.
REQ-027 Three back-to-back pixels 24'h0f0000, 24'h000f00, 24'h00000f -> three pix_valid with pix_idx 0, 1, 2 and matching data; a single frame_end at the end.
REQ-028 High pulse of 3 cycles mid-pixel -> err one cycle, no pix_valid; the next pixel decodes only after a 1350-cycle gap.
REQ-029 High pulse of 40 cycles -> err when the count reaches 32; no pix_valid until after the next gap.
REQ-030 10 bits followed by a 1350-cycle low -> frame_end and err in the same cycle, no pix_valid.
REQ-031 rst_n pulsed low after 12 bits -> all outputs 0; a subsequent full pixel is ignored unless preceded by a 1350-cycle gap.
